opcode_fetch_unit: RTL and testbench
====================================

Name: opcode_fetch_unit

Overview:
Parametrised successor of the instruction-fetch path: a BCD instruction-pointer counter, an external ROM read port with configurable latency, and a one-hot opcode decoder, sequenced by an FSM. Adds to the previous generation:
- registered timing on a single clock
- jump (absolute IP load)
- a valid/ready opcode handshake toward the sequencer
- generalised IP digit count, instruction width and ROM latency

Sits between the machine sequencer (consumer of opcodes) and program ROM.

Parameters:
IP_DIGITS, 6, number of BCD digits in IP; IP width = 4*IP_DIGITS
INSN_WIDTH, 4, ROM instruction word width; opcode width = 2**INSN_WIDTH
ROM_LATENCY, 1, cycles from RomRd high to RomData valid (1..4)

Ports:
Clk  in  1  clock, all logic on rising edge
Rst  in  1  synchronous active-high reset
Step  in  1  request next opcode; one-cycle pulse, accepted only when Busy=0
Reverse  in  1  sampled with Step; 1 = decrement IP, 0 = increment
Jump  in  1  load IP from JumpAddr and fetch; accepted only when Busy=0
JumpAddr  in  4*IP_DIGITS  BCD jump target
RomRd  out  1  one-cycle ROM read strobe
RomAddr  out  4*IP_DIGITS  ROM address, equals Ip
RomData  in  INSN_WIDTH  ROM word, valid ROM_LATENCY cycles after RomRd
Ip  out  4*IP_DIGITS  current BCD instruction pointer
Opcode  out  2**INSN_WIDTH  one-hot decoded opcode, bit RomData set
OpcodeValid  out  1  Opcode valid
OpcodeReady  in  1  consumer accepts Opcode
Busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: Ip=0, Opcode=0, OpcodeValid=0, RomRd=0, state=FETCH. An automatic fetch of address 0 follows reset release.
- States:
  - IDLE: Busy=0.
    - Jump → load Ip=JumpAddr, go to FETCH.
    - else Step → Ip±1 (BCD), go to FETCH.
    - Jump has priority over a simultaneous Step.
  - FETCH: RomRd=1 for exactly one cycle at RomAddr=Ip; go to WAIT.
  - WAIT: count ROM_LATENCY cycles. On the last count, register Opcode = 1<<RomData and set OpcodeValid=1; go to HOLD.
  - HOLD: Opcode and OpcodeValid stable. If OpcodeValid && OpcodeReady, clear OpcodeValid and go to IDLE in the same edge.
- Latency: Step accepted at edge N → RomRd high in cycle N+1 → OpcodeValid high from cycle N+2+ROM_LATENCY.
- Step/Jump arriving while Busy=1 are dropped, not queued. The consumer must wait for Busy=0.
- Ip updates on the accepting edge and stays constant through FETCH/WAIT/HOLD.
- BCD arithmetic: per-digit carry/borrow; digits never take values A–F.
  - Forward wrap: all-9 → 0.
  - Reverse wrap: 0 → all-9.
- JumpAddr containing a non-BCD digit: that digit is loaded as 0.
- Rst asserted in any state: immediate return to reset values; an in-flight ROM read is discarded.
- Opcode is 0 whenever OpcodeValid=0.

Optional Feature:
Macro IP_BOUNDARY_HALT_EN.
- Defined: adds output port Halted (1 bit, reset 0). A Step that would wrap Ip (forward at all-9, reverse at 0) does not change Ip and starts no fetch. It sets Halted=1 and the FSM stays in IDLE with Busy=1. Only Jump (clears Halted, fetches) or Rst leaves this condition.
- Undefined: no Halted port; Ip wraps as specified above.

Decomposition:
- Package dpc_fetch_pkg:
  - fetch FSM state enum (IDLE, FETCH, WAIT, HOLD)
  - BCD digit typedef
  - one-hot opcode index constants (opcode names for INSN_WIDTH=4)
  - function for single-digit BCD increment/decrement with carry
- Sub-module bcd_ip_counter (parameter IP_DIGITS): synchronous load/step/reverse, carry-out for wrap detection.
- Decoder stays inline.

Test Plan:
1. Reset, ROM[0]=3, ROM_LATENCY=1, OpcodeReady=1 → RomRd at cycle 1 with RomAddr=0; Opcode=16'h0008 with OpcodeValid for one cycle; Busy falls.
2. Ip=000099, Step with Reverse=0 → Ip=000100, RomAddr=000100. Then Step with Reverse=1 → Ip=000099.
3. Ip=0, Step with Reverse=1 (macro off) → Ip=999999. With macro on: Ip stays 0, Halted=1; then Jump to 000005 → Halted=0 and fetch at 000005.
4. OpcodeReady=0 for 5 cycles with OpcodeValid=1 → Opcode stable; a Step pulse during the hold is ignored and Ip is unchanged.
5. Jump=1 and Step=1 in the same cycle, JumpAddr=000042 → Ip=000042, single RomRd. Repeat with ROM_LATENCY=3: OpcodeValid appears 4 cycles after RomRd.
6. Rst asserted in the cycle after RomRd → Ip=0, OpcodeValid stays 0, and a fresh fetch of address 0 follows.

Source files
------------

// File: rtl/dpc_fetch_pkg.sv
// rtl/dpc_fetch_pkg.sv - shared types, opcode indices and BCD digit helpers for the opcode fetch unit
//
// Contents:
//   fetch_state_t  : fetch FSM states (IDLE, FETCH, WAIT, HOLD)
//   bcd_digit_t    : one packed BCD digit
//   bcd_step_t     : digit result plus carry/borrow out
//   OP_*           : one-hot bit index of each opcode for a 4-bit instruction word
//   bcd_digit_step : single-digit BCD increment/decrement with carry in/out
//   bcd_sanitize   : forces a non-BCD nibble to 0
package dpc_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } fetch_state_t;

  typedef logic [3:0] bcd_digit_t;

  typedef struct packed {
    logic       carry;
    bcd_digit_t digit;
  } bcd_step_t;

  localparam int unsigned OP_NOP        = 0;
  localparam int unsigned OP_INC        = 1;
  localparam int unsigned OP_DEC        = 2;
  localparam int unsigned OP_RIGHT      = 3;
  localparam int unsigned OP_LEFT       = 4;
  localparam int unsigned OP_OUT        = 5;
  localparam int unsigned OP_IN         = 6;
  localparam int unsigned OP_LOOP_BEGIN = 7;
  localparam int unsigned OP_LOOP_END   = 8;
  localparam int unsigned OP_LOAD       = 9;
  localparam int unsigned OP_STORE      = 10;
  localparam int unsigned OP_ADD        = 11;
  localparam int unsigned OP_SUB        = 12;
  localparam int unsigned OP_CLEAR      = 13;
  localparam int unsigned OP_SKIP       = 14;
  localparam int unsigned OP_HALT       = 15;

  // cin=0 passes the digit through; cin=1 adds or subtracts one with
  // carry (9->0) or borrow (0->9) reported in the result.
  function automatic bcd_step_t bcd_digit_step(input bcd_digit_t d, input logic dec,
                                               input logic cin);
    bcd_step_t r;
    r.carry = 1'b0;
    r.digit = d;
    if (cin) begin
      if (dec) begin
        if (d == 4'd0) begin
          r.digit = 4'd9;
          r.carry = 1'b1;
        end else begin
          r.digit = d - 4'd1;
        end
      end else begin
        if (d >= 4'd9) begin
          r.digit = 4'd0;
          r.carry = 1'b1;
        end else begin
          r.digit = d + 4'd1;
        end
      end
    end
    return r;
  endfunction

  function automatic bcd_digit_t bcd_sanitize(input bcd_digit_t d);
    return (d > 4'd9) ? 4'd0 : d;
  endfunction

endpackage

// File: rtl/bcd_ip_counter.sv
// rtl/bcd_ip_counter.sv - multi-digit BCD instruction pointer with load, step and wrap detect
//
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset (ip_o -> 0)
//   load_i       : load load_val_i (non-BCD digits become 0); wins over step_i
//   load_val_i   : BCD load value
//   step_i       : add one (reverse_i=0) or subtract one (reverse_i=1)
//   reverse_i    : step direction
//   ip_o         : current pointer
//   wrap_o       : a step in the current direction would wrap (all-9 up, 0 down)
module bcd_ip_counter
  import dpc_fetch_pkg::*;
#(
  parameter int IP_DIGITS = 6
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   load_i,
  input  logic [4*IP_DIGITS-1:0] load_val_i,
  input  logic                   step_i,
  input  logic                   reverse_i,
  output logic [4*IP_DIGITS-1:0] ip_o,
  output logic                   wrap_o
);

  localparam int W = 4 * IP_DIGITS;

  logic [W-1:0] ip_q;
  logic [W-1:0] ip_d;
  logic [W-1:0] ip_stepped;
  logic [W-1:0] load_clean;

  // Ripple the +/-1 through the digits; the final carry is the wrap flag.
  always_comb begin
    bcd_step_t r;
    logic      c;
    c          = 1'b1;
    ip_stepped = '0;
    for (int i = 0; i < IP_DIGITS; i++) begin
      r                   = bcd_digit_step(ip_q[4*i +: 4], reverse_i, c);
      ip_stepped[4*i +: 4] = r.digit;
      c                   = r.carry;
    end
    wrap_o = c;
  end

  always_comb begin
    load_clean = '0;
    for (int i = 0; i < IP_DIGITS; i++) begin
      load_clean[4*i +: 4] = bcd_sanitize(load_val_i[4*i +: 4]);
    end
  end

  always_comb begin
    ip_d = ip_q;
    if (load_i) begin
      ip_d = load_clean;
    end else if (step_i) begin
      ip_d = ip_stepped;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ip_q <= '0;
    end else begin
      ip_q <= ip_d;
    end
  end

  assign ip_o = ip_q;

endmodule

// File: rtl/opcode_fetch_unit.sv
// rtl/opcode_fetch_unit.sv - BCD instruction pointer, ROM read sequencing and one-hot opcode decode
//
// Optional build macro: IP_BOUNDARY_HALT_EN (adds Halted; wrapping steps halt instead).
//
// Ports:
//   Clk, Rst     : clock, synchronous active-high reset
//   Step         : request next opcode (IDLE only); Reverse selects decrement
//   Jump         : load Ip from JumpAddr and fetch (IDLE only, beats Step)
//   RomRd        : one-cycle read strobe, RomAddr = Ip
//   RomData      : ROM word, valid ROM_LATENCY cycles after RomRd
//   Ip           : current BCD instruction pointer
//   Opcode       : one-hot decode of RomData, 0 while OpcodeValid=0
//   OpcodeValid  : valid/ready handshake with OpcodeReady
//   Busy         : high outside IDLE (and while halted)
//   Halted       : only with IP_BOUNDARY_HALT_EN
module opcode_fetch_unit
  import dpc_fetch_pkg::*;
#(
  parameter int IP_DIGITS   = 6,
  parameter int INSN_WIDTH  = 4,
  parameter int ROM_LATENCY = 1
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     Step,
  input  logic                     Reverse,
  input  logic                     Jump,
  input  logic [4*IP_DIGITS-1:0]   JumpAddr,
  output logic                     RomRd,
  output logic [4*IP_DIGITS-1:0]   RomAddr,
  input  logic [INSN_WIDTH-1:0]    RomData,
  output logic [4*IP_DIGITS-1:0]   Ip,
  output logic [2**INSN_WIDTH-1:0] Opcode,
  output logic                     OpcodeValid,
  input  logic                     OpcodeReady,
  output logic                     Busy
`ifdef IP_BOUNDARY_HALT_EN
  ,
  output logic                     Halted
`endif
);

  localparam int OPW = 2 ** INSN_WIDTH;
  localparam logic [2:0] WAIT_LAST = 3'(ROM_LATENCY - 1);

  fetch_state_t    state_q;
  logic            rom_rd_q;
  logic [2:0]      wait_cnt_q;
  logic [OPW-1:0]  opcode_q;
  logic            valid_q;
  logic            ip_load;
  logic            ip_step;
  logic            ip_wrap;
`ifdef IP_BOUNDARY_HALT_EN
  logic            halted_q;
`else
  logic            unused_ip_wrap;
  assign unused_ip_wrap = ip_wrap;
`endif

  assign ip_load = (state_q == ST_IDLE) && Jump;
`ifdef IP_BOUNDARY_HALT_EN
  assign ip_step = (state_q == ST_IDLE) && !Jump && Step && !halted_q && !ip_wrap;
`else
  assign ip_step = (state_q == ST_IDLE) && !Jump && Step;
`endif

  bcd_ip_counter #(
    .IP_DIGITS (IP_DIGITS)
  ) u_ip (
    .clk_i      (Clk),
    .rst_i      (Rst),
    .load_i     (ip_load),
    .load_val_i (JumpAddr),
    .step_i     (ip_step),
    .reverse_i  (Reverse),
    .ip_o       (Ip),
    .wrap_o     (ip_wrap)
  );

  // FETCH with rom_rd_q low only happens right after reset: raise the strobe
  // first so the ROM always sees a full registered read cycle.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= ST_FETCH;
      rom_rd_q   <= 1'b0;
      wait_cnt_q <= '0;
      opcode_q   <= '0;
      valid_q    <= 1'b0;
`ifdef IP_BOUNDARY_HALT_EN
      halted_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (Jump) begin
            state_q  <= ST_FETCH;
            rom_rd_q <= 1'b1;
`ifdef IP_BOUNDARY_HALT_EN
            halted_q <= 1'b0;
`endif
          end else if (Step) begin
`ifdef IP_BOUNDARY_HALT_EN
            if (ip_wrap) begin
              halted_q <= 1'b1;
            end else if (!halted_q) begin
              state_q  <= ST_FETCH;
              rom_rd_q <= 1'b1;
            end
`else
            state_q  <= ST_FETCH;
            rom_rd_q <= 1'b1;
`endif
          end
        end
        ST_FETCH: begin
          if (rom_rd_q) begin
            state_q    <= ST_WAIT;
            rom_rd_q   <= 1'b0;
            wait_cnt_q <= '0;
          end else begin
            rom_rd_q <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (wait_cnt_q == WAIT_LAST) begin
            opcode_q <= OPW'(1) << RomData;
            valid_q  <= 1'b1;
            state_q  <= ST_HOLD;
          end else begin
            wait_cnt_q <= wait_cnt_q + 3'd1;
          end
        end
        ST_HOLD: begin
          if (valid_q && OpcodeReady) begin
            valid_q  <= 1'b0;
            opcode_q <= '0;
            state_q  <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign RomRd       = rom_rd_q;
  assign RomAddr     = Ip;
  assign Opcode      = opcode_q;
  assign OpcodeValid = valid_q;
`ifdef IP_BOUNDARY_HALT_EN
  assign Halted      = halted_q;
  assign Busy        = (state_q != ST_IDLE) || halted_q;
`else
  assign Busy        = (state_q != ST_IDLE);
`endif

endmodule

// File: tb/tb_opcode_fetch_unit.sv
// tb/tb_opcode_fetch_unit.sv - directed scoreboard bench for opcode_fetch_unit
module tb_opcode_fetch_unit;

  typedef struct {
    logic [23:0] ip;
    logic [15:0] op;
  } exp_t;

  logic        Clk = 1'b0;
  logic        Rst, Step, Reverse, Jump, OpcodeReady;
  logic [23:0] JumpAddr;
  logic        RomRd, OpcodeValid, Busy;
  logic [23:0] RomAddr, Ip;
  logic [3:0]  RomData;
  logic [15:0] Opcode;

  logic        Rst3, Step3, Reverse3, Jump3;
  logic [23:0] JumpAddr3;
  logic        RomRd3, OpcodeValid3, Busy3;
  logic [23:0] RomAddr3, Ip3;
  logic [3:0]  RomData3;
  logic [15:0] Opcode3;
`ifdef IP_BOUNDARY_HALT_EN
  logic        Halted, Halted3;
`endif

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   last_rd_cyc = 0;
  int   rd_cnt1 = 0;
  logic sel = 1'b0;
  exp_t sb_q[$];

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;
  always @(posedge Clk) if (RomRd) rd_cnt1 <= rd_cnt1 + 1;

  opcode_fetch_unit #(.IP_DIGITS(6), .INSN_WIDTH(4), .ROM_LATENCY(1)) u_dut (
    .Clk(Clk), .Rst(Rst), .Step(Step), .Reverse(Reverse), .Jump(Jump), .JumpAddr(JumpAddr),
    .RomRd(RomRd), .RomAddr(RomAddr), .RomData(RomData), .Ip(Ip), .Opcode(Opcode),
    .OpcodeValid(OpcodeValid), .OpcodeReady(OpcodeReady), .Busy(Busy)
`ifdef IP_BOUNDARY_HALT_EN
    , .Halted(Halted)
`endif
  );

  opcode_fetch_unit #(.IP_DIGITS(6), .INSN_WIDTH(4), .ROM_LATENCY(3)) u_dut3 (
    .Clk(Clk), .Rst(Rst3), .Step(Step3), .Reverse(Reverse3), .Jump(Jump3), .JumpAddr(JumpAddr3),
    .RomRd(RomRd3), .RomAddr(RomAddr3), .RomData(RomData3), .Ip(Ip3), .Opcode(Opcode3),
    .OpcodeValid(OpcodeValid3), .OpcodeReady(OpcodeReady), .Busy(Busy3)
`ifdef IP_BOUNDARY_HALT_EN
    , .Halted(Halted3)
`endif
  );

  // ROM contents: a fixed hash of the BCD address, never 15 (15 marks "not valid yet")
  function automatic logic [3:0] rom_word(input logic [23:0] a);
    int s;
    s = 3 + 3 * int'(a[3:0]) + 5 * int'(a[7:4]) + 7 * int'(a[11:8])
          + int'(a[15:12]) + int'(a[19:16]) + int'(a[23:20]);
    return 4'(s % 15);
  endfunction

  logic       rv1 = 1'b0;
  logic [3:0] rw1 = 4'h0;
  always @(posedge Clk) begin
    rv1 <= RomRd;
    rw1 <= rom_word(RomAddr);
  end
  assign RomData = rv1 ? rw1 : 4'hF;

  logic [2:0] rv3 = 3'b000;
  logic [3:0] rw3 [3];
  always @(posedge Clk) begin
    rv3    <= {rv3[1:0], RomRd3};
    rw3[0] <= rom_word(RomAddr3);
    rw3[1] <= rw3[0];
    rw3[2] <= rw3[1];
  end
  assign RomData3 = rv3[2] ? rw3[2] : 4'hF;

  logic        m_rd, m_valid, m_busy;
  logic [23:0] m_addr, m_ip;
  logic [15:0] m_op;
  assign m_rd    = sel ? RomRd3 : RomRd;
  assign m_valid = sel ? OpcodeValid3 : OpcodeValid;
  assign m_busy  = sel ? Busy3 : Busy;
  assign m_addr  = sel ? RomAddr3 : RomAddr;
  assign m_ip    = sel ? Ip3 : Ip;
  assign m_op    = sel ? Opcode3 : Opcode;

  // Reference BCD arithmetic via integer conversion, modulo 10^6
  function automatic logic [23:0] bcd_add(input logic [23:0] a, input int delta);
    int          v;
    int          p;
    logic [23:0] r;
    v = 0;
    p = 1;
    r = '0;
    for (int i = 0; i < 6; i++) begin
      v += int'(a[4*i +: 4]) * p;
      p *= 10;
    end
    v = (v + delta + 1000000) % 1000000;
    for (int i = 0; i < 6; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #2;
  endtask

  task automatic clear_pulses();
    Step = 1'b0; Jump = 1'b0; Step3 = 1'b0; Jump3 = 1'b0;
  endtask

  task automatic pulse(input bit st, input bit jp, input bit rv, input logic [23:0] a);
    if (sel) begin
      Step3 = st; Jump3 = jp; Reverse3 = rv; JumpAddr3 = a;
    end else begin
      Step = st; Jump = jp; Reverse = rv; JumpAddr = a;
    end
  endtask

  task automatic push_exp(input logic [23:0] ip);
    exp_t e;
    e.ip = ip;
    e.op = 16'(1) << rom_word(ip);
    sb_q.push_back(e);
  endtask

  // Waits for the read strobe, then checks address, one-cycle strobe,
  // valid latency and decoded opcode against the scoreboard head.
  task automatic check_fetch(input int lat, input bit ready_hs);
    int   n;
    int   rd_cyc;
    exp_t e;
    n = 0;
    do begin
      tick();
      clear_pulses();
      n++;
    end while (!m_rd && n < 20);
    check("romrd_seen", m_rd, 1);
    check("sb_depth", sb_q.size() != 0, 1);
    if (sb_q.size() == 0) return;
    e = sb_q.pop_front();
    check("romaddr", m_addr, e.ip);
    check("ip_at_fetch", m_ip, e.ip);
    check("valid_during_fetch", m_valid, 0);
    rd_cyc = cyc;
    last_rd_cyc = cyc;
    tick();
    check("romrd_one_cycle", m_rd, 0);
    n = 0;
    while (!m_valid && n < 20) begin
      tick();
      n++;
    end
    check("valid_latency", cyc - rd_cyc, lat + 1);
    check("opcode", m_op, e.op);
    check("ip_stable", m_ip, e.ip);
    check("busy_in_hold", m_busy, 1);
    if (ready_hs) begin
      tick();
      check("valid_cleared", m_valid, 0);
      check("opcode_cleared", m_op, 0);
      check("busy_released", m_busy, 0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] mip;
    logic [15:0] hop;
    int          rel;
    int          rd_before;

    Rst = 1'b1; Step = 1'b0; Reverse = 1'b0; Jump = 1'b0; JumpAddr = '0; OpcodeReady = 1'b1;
    Rst3 = 1'b1; Step3 = 1'b0; Reverse3 = 1'b0; Jump3 = 1'b0; JumpAddr3 = '0;
    mip = '0;

    // 1: reset state, auto fetch of address 0 (ROM[0]=3)
    repeat (3) tick();
    check("rst_ip", Ip, 0);
    check("rst_opcode", Opcode, 0);
    check("rst_valid", OpcodeValid, 0);
    check("rst_romrd", RomRd, 0);
    check("rst_busy", Busy, 1);
    push_exp(24'h000000);
    check("rom0_is_3", 16'(1) << rom_word(24'h000000), 16'h0008);
    Rst = 1'b0;
    rel = cyc;
    check_fetch(1, 1);
    check("rd_after_reset_cycle", last_rd_cyc - rel, 1);

    // 2: BCD carry across digits and back
    pulse(0, 1, 0, 24'h000099); mip = 24'h000099; push_exp(mip); check_fetch(1, 1);
    pulse(1, 0, 0, 24'h0); mip = bcd_add(mip, 1); push_exp(mip); check_fetch(1, 1);
    check("ip_000100", Ip, 24'h000100);
    pulse(1, 0, 1, 24'h0); mip = bcd_add(mip, -1); push_exp(mip); check_fetch(1, 1);
    check("ip_000099", Ip, 24'h000099);

    // 3: wrap at the boundaries
    pulse(0, 1, 0, 24'h000000); mip = 24'h000000; push_exp(mip); check_fetch(1, 1);
`ifdef IP_BOUNDARY_HALT_EN
    pulse(1, 0, 1, 24'h0);
    tick(); clear_pulses(); tick(); tick();
    check("halt_ip", Ip, 24'h000000);
    check("halt_flag", Halted, 1);
    check("halt_busy", Busy, 1);
    check("halt_no_rd", RomRd, 0);
    pulse(0, 1, 0, 24'h000005); mip = 24'h000005; push_exp(mip); check_fetch(1, 1);
    check("halt_cleared", Halted, 0);
`else
    pulse(1, 0, 1, 24'h0); mip = bcd_add(mip, -1); push_exp(mip); check_fetch(1, 1);
    check("rev_wrap", Ip, 24'h999999);
    pulse(1, 0, 0, 24'h0); mip = bcd_add(mip, 1); push_exp(mip); check_fetch(1, 1);
    check("fwd_wrap", Ip, 24'h000000);
`endif

    // 4: back-pressure; non-BCD jump digits load as 0; Step during HOLD dropped
    OpcodeReady = 1'b0;
    pulse(0, 1, 0, 24'h00A0B7); mip = 24'h000007; push_exp(mip);
    hop = 16'(1) << rom_word(mip);
    check_fetch(1, 0);
    for (int k = 0; k < 5; k++) begin
      Step = (k == 1);
      tick();
      check("hold_valid", OpcodeValid, 1);
      check("hold_opcode", Opcode, hop);
      check("hold_ip", Ip, mip);
    end
    Step = 1'b0;
    OpcodeReady = 1'b1;
    tick();
    check("hold_release_valid", OpcodeValid, 0);
    check("hold_release_busy", Busy, 0);
    tick(); tick();
    check("dropped_step_no_rd", RomRd, 0);
    check("dropped_step_ip", Ip, mip);

    // 5: Jump beats Step; single read; then ROM_LATENCY=3 instance
    rd_before = rd_cnt1;
    pulse(1, 1, 0, 24'h000042); mip = 24'h000042; push_exp(mip); check_fetch(1, 1);
    tick(); tick();
    check("single_romrd", rd_cnt1 - rd_before, 1);
    check("jump_prio_ip", Ip, 24'h000042);

    sel = 1'b1;
    push_exp(24'h000000);
    Rst3 = 1'b0;
    check_fetch(3, 1);
    pulse(1, 1, 0, 24'h000042); push_exp(24'h000042); check_fetch(3, 1);
    check("lat3_ip", Ip3, 24'h000042);
    sel = 1'b0;

    // 6: reset while a read is in flight
    pulse(1, 0, 0, 24'h0); mip = bcd_add(mip, 1);
    tick(); clear_pulses();
    check("pre_rst_rd", RomRd, 1);
    check("pre_rst_addr", RomAddr, mip);
    tick();
    Rst = 1'b1;
    tick();
    check("rst_mid_ip", Ip, 0);
    check("rst_mid_valid", OpcodeValid, 0);
    check("rst_mid_rd", RomRd, 0);
    tick();
    check("rst_mid_valid2", OpcodeValid, 0);
    push_exp(24'h000000);
    Rst = 1'b0;
    rel = cyc;
    check_fetch(1, 1);
    check("refetch_cycle", last_rd_cyc - rel, 1);
    check("sb_drained", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
